// File: rtl/fsm_mestre_envase.sv
// rtl/fsm_mestre_envase.sv - master sequencer of the bottling line (conveyor, filler, sealer handshakes)
//
// Purpose: moves the conveyor until a bottle is in position, then runs a
//   4-phase cmd/concluido handshake with the filler and then with the sealer.
//   It counts finished bottles with a saturating counter. A stopper alarm
//   parks the line in ALARME until the alarm clears and start is given.
//   Moore machine: every output is a registered decode of the state.
// Optional feature: define WATCHDOG_EN to enable the per-phase watchdog
//   (TIMEOUT_CICLOS cycles in a handshake state -> FALHA).
// Ports:
//   clk, reset_n (async, active-low)
//   start, stop, sensor_posicao, enchimento_concluido, vedacao_concluida,
//   alarme_rolha                                       - line inputs
//   motor_esteira, cmd_encher, cmd_vedar               - actuator commands
//   alarme_ativo, falha                                - status flags
//   garrafas_ok [W_CONT]                               - finished-bottle count
//   estado_dbg [4]                                     - current state code
module fsm_mestre_envase #(
  parameter int TIMEOUT_CICLOS = 100000000,
  parameter int W_CONT         = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              sensor_posicao,
  input  logic              enchimento_concluido,
  input  logic              vedacao_concluida,
  input  logic              alarme_rolha,
  output logic              motor_esteira,
  output logic              cmd_encher,
  output logic              cmd_vedar,
  output logic              alarme_ativo,
  output logic              falha,
  output logic [W_CONT-1:0] garrafas_ok,
  output logic [3:0]        estado_dbg
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_MOVER   = 4'd1,
    S_ENCHER  = 4'd2,
    S_ENC_LIB = 4'd3,
    S_VEDAR   = 4'd4,
    S_VED_LIB = 4'd5,
    S_SAIR    = 4'd6,
    S_ALARME  = 4'd7,
    S_FALHA   = 4'd8
  } state_t;

  state_t              state_q, state_d;
  logic [W_CONT-1:0]   cont_q, cont_d;
  logic                motor_q, motor_d;
  logic                encher_q, encher_d;
  logic                vedar_q, vedar_d;
  logic                alarme_q, alarme_d;

`ifdef WATCHDOG_EN
  localparam int            WD_W   = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CICLOS - 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            falha_q, falha_d;
  logic            em_handshake;
`endif

  always_comb begin
    state_d = state_q;
    cont_d  = cont_q;

    // stop outranks every other condition, including a concluido on the same edge
    if (state_q != S_IDLE && stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (start) state_d = S_MOVER;
        S_MOVER:   if (sensor_posicao) state_d = S_ENCHER;
        S_ENCHER:  if (enchimento_concluido) state_d = S_ENC_LIB;
        S_ENC_LIB: if (!enchimento_concluido) state_d = alarme_rolha ? S_ALARME : S_VEDAR;
        S_VEDAR: begin
          if (alarme_rolha)           state_d = S_ALARME;
          else if (vedacao_concluida) state_d = S_VED_LIB;
        end
        S_VED_LIB: begin
          // the bottle is counted only once the sealer has released its done flag
          if (!vedacao_concluida) begin
            state_d = S_SAIR;
            if (cont_q != '1) cont_d = cont_q + W_CONT'(1);
          end
        end
        S_SAIR:    if (!sensor_posicao) state_d = S_MOVER;
        // retry sealing of the same bottle; it is already filled
        S_ALARME:  if (!alarme_rolha && start) state_d = S_VEDAR;
        S_FALHA:   state_d = S_FALHA;
        default:   state_d = S_IDLE;
      endcase
    end

`ifdef WATCHDOG_EN
    em_handshake = (state_q == S_ENCHER) || (state_q == S_ENC_LIB) ||
                   (state_q == S_VEDAR)  || (state_q == S_VED_LIB);
    wdog_d = '0;
    // the timeout only fires when nothing else moved the machine this cycle
    if (em_handshake && state_d == state_q) begin
      if (wdog_q == WD_MAX) state_d = S_FALHA;
      else                  wdog_d  = wdog_q + WD_W'(1);
    end
    falha_d = (state_d == S_FALHA);
`endif

    motor_d  = (state_d == S_MOVER) || (state_d == S_SAIR);
    encher_d = (state_d == S_ENCHER);
    vedar_d  = (state_d == S_VEDAR);
    alarme_d = (state_d == S_ALARME);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cont_q   <= '0;
      motor_q  <= 1'b0;
      encher_q <= 1'b0;
      vedar_q  <= 1'b0;
      alarme_q <= 1'b0;
`ifdef WATCHDOG_EN
      wdog_q   <= '0;
      falha_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cont_q   <= cont_d;
      motor_q  <= motor_d;
      encher_q <= encher_d;
      vedar_q  <= vedar_d;
      alarme_q <= alarme_d;
`ifdef WATCHDOG_EN
      wdog_q   <= wdog_d;
      falha_q  <= falha_d;
`endif
    end
  end

  assign motor_esteira = motor_q;
  assign cmd_encher    = encher_q;
  assign cmd_vedar     = vedar_q;
  assign alarme_ativo  = alarme_q;
  assign garrafas_ok   = cont_q;
  assign estado_dbg    = state_q;
`ifdef WATCHDOG_EN
  assign falha         = falha_q;
`else
  assign falha         = 1'b0;
`endif

endmodule
